// File: rtl/sq_rebuild.sv
// sq_rebuild: rebuilds a square-root radicand, result = root*root + rem.
// It is a sequential shift-add squarer that processes one multiplier bit per
// clock. It uses the calculator's init/busy/done handshake and flags
// remainder values that no square-root result could have produced.
module sq_rebuild #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    input  logic             init,
    input  logic [W-1:0]     root,
    input  logic [W:0]       rem,
    output logic [2*W-1:0]   result,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(W + 1);

    logic [1:0]     state;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc_sum;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           ierr;

    // Conditional add for the current multiplier bit. The carry out of 2W bits is dropped.
    always_comb begin
        acc_sum = mplier[0] ? (acc + mcand) : acc;
    end

    // Control FSM and datapath registers. The result is written only on the last iteration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            ierr   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register see the values from before the edge.
            case (state)
                S_IDLE: begin
                    if (init) begin
                        // The remainder seeds the accumulator, so the sum needs no separate final add.
                        acc    <= {{(W-1){1'b0}}, rem};
                        mcand  <= {{W{1'b0}}, root};
                        mplier <= root;
                        cnt    <= CW'(W);
                        ierr   <= (rem > {root, 1'b0});
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result <= acc_sum;
                        err    <= ierr;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_sq_rebuild.sv
// tb_sq_rebuild: self-checking bench for sq_rebuild with W=8.
// It has three parts: a table of directed vectors, hand-written sequences for
// the handshake and reset corner cases, and a randomized sweep. The sweep is
// checked against an arithmetic model and an integer square root.
module tb_sq_rebuild;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic             init;
    logic [W-1:0]     root;
    logic [W:0]       rem;
    logic [2*W-1:0]   result;
    logic             err;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    sq_rebuild #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .root   (root),
        .rem    (rem),
        .result (result),
        .err    (err),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   root;
        logic [W:0]     rem;
        logic [2*W-1:0] exp_res;
        logic           exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model, taken straight from the arithmetic definition.
    function automatic logic [2*W-1:0] model_res(input int r, input int m);
        return (2*W)'((r * r + m) % (1 << (2*W)));
    endfunction

    function automatic logic model_err(input int r, input int m);
        return (m > 2 * r);
    endfunction

    function automatic int isqrt(input int v);
        int s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    // Run one operation and wait a bounded time for done.
    // lat counts the rising edges from the sampling edge to the done cycle.
    // bcnt counts the cycles in which busy is high.
    task automatic do_op(input logic [W-1:0] r, input logic [W:0] m,
                         output logic [2*W-1:0] res, output logic e,
                         output int lat, output int bcnt, output bit ok);
        @(negedge clk);
        root = r;
        rem  = m;
        init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        lat  = 0;
        bcnt = 0;
        ok   = 1'b0;
        res  = '0;
        e    = 1'b0;
        while (!ok && lat < 40) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                ok  = 1'b1;
                res = result;
                e   = err;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!ok) check("done_timeout", 32'(lat), 32'(W));
    endtask

    initial begin
        logic [2*W-1:0] res;
        logic           e;
        int             lat;
        int             bcnt;
        bit             ok;
        int             strobe_t[$];
        int             strobe_seen;

        vecs[0]  = '{8'd12,  9'd5,   16'd149,   1'b0};
        vecs[1]  = '{8'd255, 9'd510, 16'hFFFF,  1'b0};
        vecs[2]  = '{8'd0,   9'd0,   16'd0,     1'b0};
        vecs[3]  = '{8'd3,   9'd7,   16'd16,    1'b1};
        vecs[4]  = '{8'd3,   9'd6,   16'd15,    1'b0};
        vecs[5]  = '{8'd0,   9'd511, 16'd511,   1'b1};
        vecs[6]  = '{8'd255, 9'd511, 16'd0,     1'b1};
        vecs[7]  = '{8'd7,   9'd1,   16'd50,    1'b0};
        vecs[8]  = '{8'd1,   9'd2,   16'd3,     1'b0};
        vecs[9]  = '{8'd1,   9'd3,   16'd4,     1'b1};
        vecs[10] = '{8'd16,  9'd0,   16'd256,   1'b0};
        vecs[11] = '{8'd170, 9'd85,  16'd28985, 1'b0};

        // Reset state.
        rst  = 1'b0;
        init = 1'b0;
        root = '0;
        rem  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", 32'(result), 32'd0);
        check("reset_err",    32'(err),    32'd0);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: latency, busy length, and result holding after done.
        do_op(8'd12, 9'd5, res, e, lat, bcnt, ok);
        check("t1_latency", 32'(lat),  32'(W));
        check("t1_busy",    32'(bcnt), 32'(W + 1));
        check("t1_result",  32'(res),  32'd149);
        check("t1_err",     32'(e),    32'd0);
        repeat (3) @(negedge clk);
        check("t1_done_one_cycle", 32'(done),   32'd0);
        check("t1_hold_result",    32'(result), 32'd149);
        check("t1_idle",           32'(busy),   32'd0);

        // Directed vector table.
        foreach (vecs[i]) begin
            do_op(vecs[i].root, vecs[i].rem, res, e, lat, bcnt, ok);
            check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_err", i),    32'(e),   32'(vecs[i].exp_err));
        end

        // Test 4: init is held high, and root is changed while CALC is running.
        @(negedge clk);
        root = 8'd5;
        rem  = 9'd0;
        init = 1'b1;
        strobe_seen = 0;
        for (int t = 0; t < 60 && strobe_seen < 3; t++) begin
            @(negedge clk);
            if (done) begin
                strobe_t.push_back(t);
                strobe_seen++;
                check($sformatf("t4_result%0d", strobe_seen), 32'(result), 32'd25);
                root = 8'd5;
            end else if (busy) begin
                root = W'($urandom);
            end
        end
        init = 1'b0;
        check("t4_strobes", 32'(strobe_seen), 32'd3);
        if (strobe_t.size() == 3) begin
            check("t4_period_a", 32'(strobe_t[1] - strobe_t[0]), 32'(W + 2));
            check("t4_period_b", 32'(strobe_t[2] - strobe_t[1]), 32'(W + 2));
        end
        repeat (4) @(negedge clk);

        // Test 5: asynchronous reset between clock edges while CALC is running.
        @(negedge clk);
        root = 8'd9;
        rem  = 9'd3;
        init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t5_async_result", 32'(result), 32'd0);
        check("t5_async_busy",   32'(busy),   32'd0);
        check("t5_async_done",   32'(done),   32'd0);
        check("t5_async_err",    32'(err),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        strobe_seen = 0;
        for (int t = 0; t < 2 * W; t++) begin
            @(negedge clk);
            if (done || busy) strobe_seen++;
        end
        check("t5_no_done_after_abort", 32'(strobe_seen), 32'd0);
        do_op(8'd7, 9'd1, res, e, lat, bcnt, ok);
        check("t5_result", 32'(res), 32'd50);
        check("t5_err",    32'(e),   32'd0);

        // Test 6: sweep of every root with a random valid remainder, plus a sqrt round trip.
        for (int r = 0; r < (1 << W); r++) begin
            int m;
            int s;
            m = int'($urandom_range(0, 2 * r));
            do_op(W'(r), (W+1)'(m), res, e, lat, bcnt, ok);
            check($sformatf("sweep_r%0d_result", r), 32'(res), 32'(model_res(r, m)));
            check($sformatf("sweep_r%0d_err", r),    32'(e),   32'(model_err(r, m)));
            s = isqrt(int'(res));
            check($sformatf("sweep_r%0d_sqrt", r), 32'(s) << 16 | 32'(int'(res) - s * s),
                  32'(r) << 16 | 32'(m));
        end

        // Random pairs that may be invalid, including results that wrap.
        for (int k = 0; k < 40; k++) begin
            int r;
            int m;
            r = int'($urandom_range(0, (1 << W) - 1));
            m = int'($urandom_range(0, (1 << (W + 1)) - 1));
            do_op(W'(r), (W+1)'(m), res, e, lat, bcnt, ok);
            check($sformatf("rand%0d_result", k), 32'(res), 32'(model_res(r, m)));
            check($sformatf("rand%0d_err", k),    32'(e),   32'(model_err(r, m)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
